// File: rtl/meas_div_arbiter.sv
// Shared restoring radix-2 divider for the measurement subsystem, arbitrated between two requesters.
// Define MEAS_DIV_FIXED_PRIORITY_EN for strict priority to requester 0; default is round-robin.
module meas_div_arbiter #(
    parameter int unsigned DW_N = 40,
    parameter int unsigned DW_D = 24
) (
    input  logic            ADC_clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [DW_N-1:0] req0_dividend,
    input  logic [DW_D-1:0] req0_divisor,
    input  logic            req1_valid,
    input  logic [DW_N-1:0] req1_dividend,
    input  logic [DW_D-1:0] req1_divisor,
    output logic            gnt0,
    output logic            gnt1,
    output logic            done0,
    output logic            done1,
    output logic [DW_N-1:0] quotient,
    output logic [DW_D-1:0] remainder,
    output logic            div_zero,
    output logic            busy
);

    localparam int unsigned CW = $clog2(DW_N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_ZERO,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            winner_q, winner_d;
    logic [DW_N-1:0] dvd_q, dvd_d;
    logic [DW_D-1:0] dsr_q, dsr_d;
    logic [DW_D:0]   rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            gnt0_q, gnt0_d;
    logic            gnt1_q, gnt1_d;
    logic            done0_q, done0_d;
    logic            done1_q, done1_d;
    logic [DW_N-1:0] quotient_q, quotient_d;
    logic [DW_D-1:0] remainder_q, remainder_d;
    logic            div_zero_q, div_zero_d;
    logic            busy_q, busy_d;
`ifdef MEAS_DIV_FIXED_PRIORITY_EN
`else
    logic            last_grant_q, last_grant_d;
`endif

    logic            sel;
    logic [DW_N-1:0] cap_dividend;
    logic [DW_D-1:0] cap_divisor;
    logic [DW_D+1:0] trial;
    logic            q_bit;
    logic [DW_D:0]   rem_next;
    logic [DW_N-1:0] dvd_next;

    // Winner selection: sel=1 picks requester 1
    always_comb begin
`ifdef MEAS_DIV_FIXED_PRIORITY_EN
        sel = ~req0_valid;
`else
        sel = req1_valid & (~req0_valid | ~last_grant_q);
`endif
    end

    assign cap_dividend = sel ? req1_dividend : req0_dividend;
    assign cap_divisor  = sel ? req1_divisor  : req0_divisor;

    // One restoring step; partial remainder stays below the divisor so the top trial bit is the sign
    assign trial    = {rem_q, dvd_q[DW_N-1]} - {2'b00, dsr_q};
    assign q_bit    = ~trial[DW_D+1];
    assign rem_next = q_bit ? trial[DW_D:0] : {rem_q[DW_D-1:0], dvd_q[DW_N-1]};
    assign dvd_next = {dvd_q[DW_N-2:0], q_bit};

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        gnt0_d      = gnt0_q;
        gnt1_d      = gnt1_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
`ifdef MEAS_DIV_FIXED_PRIORITY_EN
`else
        last_grant_d = last_grant_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req0_valid | req1_valid) begin
                    winner_d = sel;
`ifdef MEAS_DIV_FIXED_PRIORITY_EN
`else
                    last_grant_d = sel;
`endif
                    dvd_d  = cap_dividend;
                    dsr_d  = cap_divisor;
                    rem_d  = '0;
                    cnt_d  = CW'(DW_N - 1);
                    gnt0_d = ~sel;
                    gnt1_d = sel;
                    state_d = (cap_divisor == '0) ? S_ZERO : S_CALC;
                end
            end
            S_CALC: begin
                dvd_d = dvd_next;
                rem_d = rem_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d     = S_DONE;
                    quotient_d  = dvd_next;
                    remainder_d = rem_next[DW_D-1:0];
                    div_zero_d  = 1'b0;
                    done0_d     = ~winner_q;
                    done1_d     = winner_q;
                end
            end
            S_ZERO: begin
                state_d     = S_DONE;
                quotient_d  = '1;
                remainder_d = '0;
                div_zero_d  = 1'b1;
                done0_d     = ~winner_q;
                done1_d     = winner_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge ADC_clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            winner_q    <= 1'b0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MEAS_DIV_FIXED_PRIORITY_EN
`else
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            busy_q      <= busy_d;
`ifdef MEAS_DIV_FIXED_PRIORITY_EN
`else
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_meas_div_arbiter.sv
// Self-checking bench for meas_div_arbiter: directed and random divisions against an arithmetic reference.
// Honours MEAS_DIV_FIXED_PRIORITY_EN in its arbitration model.
module tb_meas_div_arbiter;

    localparam int unsigned DW_N = 40;
    localparam int unsigned DW_D = 24;
    localparam longint unsigned MASK_N = (64'd1 << DW_N) - 64'd1;
    localparam longint unsigned MASK_D = (64'd1 << DW_D) - 64'd1;

    logic            ADC_clk = 1'b0;
    logic            rst;
    logic            req0_valid, req1_valid;
    logic [DW_N-1:0] req0_dividend, req1_dividend;
    logic [DW_D-1:0] req0_divisor, req1_divisor;
    logic            gnt0, gnt1, done0, done1, div_zero, busy;
    logic [DW_N-1:0] quotient;
    logic [DW_D-1:0] remainder;

    int checks = 0;
    int errors = 0;
    int last_m = 1;
    int cyc    = 0;

    meas_div_arbiter #(.DW_N(DW_N), .DW_D(DW_D)) dut (
        .ADC_clk       (ADC_clk),
        .rst           (rst),
        .req0_valid    (req0_valid),
        .req0_dividend (req0_dividend),
        .req0_divisor  (req0_divisor),
        .req1_valid    (req1_valid),
        .req1_dividend (req1_dividend),
        .req1_divisor  (req1_divisor),
        .gnt0          (gnt0),
        .gnt1          (gnt1),
        .done0         (done0),
        .done1         (done1),
        .quotient      (quotient),
        .remainder     (remainder),
        .div_zero      (div_zero),
        .busy          (busy)
    );

    always #5 ADC_clk = ~ADC_clk;

    task automatic tick();
        @(posedge ADC_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, divide-by-zero saturates the quotient
    task automatic ref_div(input longint unsigned a, input longint unsigned b,
                           output longint unsigned q, output longint unsigned r, output logic dz);
        if (b == 0) begin
            q  = MASK_N;
            r  = 0;
            dz = 1'b1;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endtask

    function automatic int pick(input bit p0, input bit p1);
`ifdef MEAS_DIV_FIXED_PRIORITY_EN
        return p0 ? 0 : 1;
`else
        if (p0 && p1) return (last_m == 1) ? 0 : 1;
        return p0 ? 0 : 1;
`endif
    endfunction

    function automatic longint unsigned rand_dvd();
        longint unsigned v;
        v = {32'($urandom), 32'($urandom)};
        return v & MASK_N;
    endfunction

    function automatic longint unsigned rand_dsr();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'($urandom_range(1, 15));
            2:       return MASK_D;
            default: return 64'($urandom_range(1, 32'hFF_FFFF));
        endcase
    endfunction

    task automatic set_req(input int who, input logic v, input longint unsigned a, input longint unsigned b);
        if (who == 0) begin
            req0_valid    = v;
            req0_dividend = a[DW_N-1:0];
            req0_divisor  = b[DW_D-1:0];
        end else begin
            req1_valid    = v;
            req1_dividend = a[DW_N-1:0];
            req1_divisor  = b[DW_D-1:0];
        end
    endtask

    // Drive a request from an idle DUT and check the capture cycle; operands are then scrambled
    task automatic start_op(input int who, input longint unsigned a, input longint unsigned b);
        set_req(who, 1'b1, a, b);
        tick();
        cyc    = 1;
        last_m = who;
        check("gnt_at_capture", (who == 0) ? gnt0 : gnt1, 64'd1);
        check("other_gnt_at_capture", (who == 0) ? gnt1 : gnt0, 64'd0);
        check("busy_at_capture", busy, 64'd1);
        set_req(who, 1'b1, rand_dvd(), rand_dsr());
    endtask

    task automatic finish_op(input int who, input longint unsigned a, input longint unsigned b);
        longint unsigned q, r;
        logic dz;
        int   lat;
        bit   other_seen;
        ref_div(a, b, q, r, dz);
        lat = (b == 0) ? 2 : int'(DW_N) + 1;
        other_seen = 1'b0;
        while (!(done0 || done1) && cyc < lat + 20) begin
            tick();
            cyc++;
            if ((who == 0) ? (gnt1 || done1) : (gnt0 || done0)) other_seen = 1'b1;
        end
        check("latency", 64'(cyc), 64'(lat));
        check("done_winner", (who == 0) ? done0 : done1, 64'd1);
        check("done_other", (who == 0) ? done1 : done0, 64'd0);
        check("other_never_granted", 64'(other_seen), 64'd0);
        check("quotient", quotient, q);
        check("remainder", remainder, r);
        check("div_zero", div_zero, 64'(dz));
        set_req(who, 1'b0, 64'd0, 64'd0);
        tick();
        check("idle_busy", busy, 64'd0);
        check("idle_gnt", (who == 0) ? gnt0 : gnt1, 64'd0);
        check("done_one_cycle", (who == 0) ? done0 : done1, 64'd0);
        check("quotient_held", quotient, q);
    endtask

    // Both requesters kept asserting; each re-requests right after its own done
    task automatic pair_run(input int n0, input int n1,
                            input longint unsigned a0, input longint unsigned b0,
                            input longint unsigned a1, input longint unsigned b1);
        longint unsigned a [2];
        longint unsigned b [2];
        int left [2];
        longint unsigned q, r;
        logic dz;
        int exp_who, lat, n;
        a[0] = a0; b[0] = b0; a[1] = a1; b[1] = b1;
        left[0] = n0; left[1] = n1;
        set_req(0, left[0] > 0, a[0], b[0]);
        set_req(1, left[1] > 0, a[1], b[1]);
        while (left[0] > 0 || left[1] > 0) begin
            exp_who = pick(left[0] > 0, left[1] > 0);
            last_m  = exp_who;
            lat = (b[exp_who] == 0) ? 2 : int'(DW_N) + 1;
            n = 0;
            do begin
                tick();
                n++;
            end while (!(done0 || done1) && n < lat + 20);
            ref_div(a[exp_who], b[exp_who], q, r, dz);
            check("pair_done0", done0, 64'(exp_who == 0));
            check("pair_done1", done1, 64'(exp_who == 1));
            check("pair_latency", 64'(n), 64'(lat));
            check("pair_quotient", quotient, q);
            check("pair_remainder", remainder, r);
            check("pair_div_zero", div_zero, 64'(dz));
            left[exp_who]--;
            set_req(exp_who, 1'b0, a[exp_who], b[exp_who]);
            tick();
            if (left[exp_who] > 0) begin
                a[exp_who] = rand_dvd();
                b[exp_who] = rand_dsr();
                set_req(exp_who, 1'b1, a[exp_who], b[exp_who]);
            end
        end
    endtask

    initial begin
        longint unsigned ra, rb;
        int who;
        rst = 1'b0;
        set_req(0, 1'b0, 64'd0, 64'd0);
        set_req(1, 1'b0, 64'd0, 64'd0);
        repeat (3) tick();
        check("rst_busy", busy, 64'd0);
        check("rst_gnt0", gnt0, 64'd0);
        check("rst_gnt1", gnt1, 64'd0);
        check("rst_done0", done0, 64'd0);
        check("rst_done1", done1, 64'd0);
        check("rst_quotient", quotient, 64'd0);
        check("rst_remainder", remainder, 64'd0);
        check("rst_div_zero", div_zero, 64'd0);
        rst = 1'b1;
        tick();
        check("post_rst_busy", busy, 64'd0);

        // Frequency path reference case
        start_op(0, 64'd40000000000, 64'd40000);
        finish_op(0, 64'd40000000000, 64'd40000);

        // Requester 1 alone
        start_op(1, 64'd40000000000, 64'd3);
        finish_op(1, 64'd40000000000, 64'd3);

        // Simultaneous requests after a fresh reset, then repeated contention
        rst = 1'b0;
        tick();
        rst = 1'b1;
        last_m = 1;
        pair_run(3, 3, 64'd100, 64'd7, 64'd1000, 64'd9);

        // Divide by zero, then a normal divide clears div_zero
        start_op(0, 64'd12345, 64'd0);
        finish_op(0, 64'd12345, 64'd0);
        start_op(0, 64'd10, 64'd2);
        finish_op(0, 64'd10, 64'd2);

        // Reset in the middle of CALC abandons the operation; the held request is recaptured
        start_op(0, 64'd987654321, 64'd1234);
        repeat (19) begin
            tick();
            cyc++;
        end
        rst = 1'b0;
        tick();
        check("midrst_busy", busy, 64'd0);
        check("midrst_gnt0", gnt0, 64'd0);
        check("midrst_done0", done0, 64'd0);
        check("midrst_quotient", quotient, 64'd0);
        check("midrst_remainder", remainder, 64'd0);
        check("midrst_div_zero", div_zero, 64'd0);
        last_m = 1;
        set_req(0, 1'b1, 64'd987654321, 64'd1234);
        rst = 1'b1;
        start_op(0, 64'd987654321, 64'd1234);
        finish_op(0, 64'd987654321, 64'd1234);

        // Operand boundaries
        start_op(1, 64'd5, MASK_D);
        finish_op(1, 64'd5, MASK_D);
        start_op(0, MASK_N, 64'd1);
        finish_op(0, MASK_N, 64'd1);

        // Random single-requester operations
        for (int i = 0; i < 16; i++) begin
            ra  = rand_dvd();
            rb  = rand_dsr();
            who = int'($urandom_range(0, 1));
            start_op(who, ra, rb);
            finish_op(who, ra, rb);
        end

        // Random contention with uneven request counts
        pair_run(4, 2, rand_dvd(), rand_dsr(), rand_dvd(), rand_dsr());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
